// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: bus widths,
// reset level, fetch exception code and the fetch FSM state encoding.
package inst_fetch_pkg;

    localparam int STALL_W  = 6;
    localparam int ADDR_W   = 32;
    localparam int INST_W   = 32;
    localparam int STALL_IF = 2;

    typedef logic [STALL_W-1:0] stall_bus_t;
    typedef logic [ADDR_W-1:0]  inst_addr_bus_t;
    typedef logic [INST_W-1:0]  inst_bus_t;

    localparam logic RST_ENABLE = 1'b0;

    localparam logic [31:0] EXC_ADEL_IF = 32'h0000_0004;

    typedef enum logic [1:0] {
        IF_REQ    = 2'd0,
        IF_WAIT   = 2'd1,
        IF_VALID  = 2'd2,
        IF_CANCEL = 2'd3
    } if_state_e;

endpackage

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over an SRAM-like port and feeds IF/ID.
// Defining IF_ADDR_CHECK_EN raises an address-error exception instead of fetching a misaligned PC.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    input  logic               branch_flag,
    input  logic [ADDR_W-1:0]  branch_target_address,
    output logic               inst_req,
    output logic [ADDR_W-1:0]  inst_addr,
    input  logic               inst_addr_ok,
    input  logic               inst_data_ok,
    input  logic [INST_W-1:0]  inst_rdata,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INST_W-1:0]  if_inst,
    output logic [31:0]        icache_excepttype,
    output logic               stallreq_if
);

    if_state_e         state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pend_target;
    logic              pend_br;
    logic [INST_W-1:0] buf_inst;
    logic              buf_adel;

    logic              hold;
    logic              misaligned;
    logic              advance;
    logic [ADDR_W-1:0] next_pc;
    logic              unused_stall;

    assign hold         = stall[STALL_IF];
    assign unused_stall = ^{stall[STALL_W-1:STALL_IF+1], stall[STALL_IF-1:0]};
    assign inst_addr    = pc;

`ifdef IF_ADDR_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // The instruction presented this cycle leaves IF at the edge unless stalled.
    assign advance = !hold && ((state == IF_WAIT && inst_data_ok) || state == IF_VALID);
    assign next_pc = branch_flag ? branch_target_address :
                     pend_br     ? pend_target           :
                                   pc + 32'd4;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        inst_req          = 1'b0;
        if_pc             = '0;
        if_inst           = '0;
        icache_excepttype = '0;
        stallreq_if       = 1'b1;
        if (rst == RST_ENABLE) begin
            stallreq_if = 1'b0;
        end else begin
            case (state)
                IF_REQ:   inst_req = !misaligned;
                IF_WAIT: begin
                    if (inst_data_ok) begin
                        if_pc       = pc;
                        if_inst     = inst_rdata;
                        stallreq_if = 1'b0;
                    end
                end
                IF_VALID: begin
                    if_pc             = pc;
                    if_inst           = buf_inst;
                    icache_excepttype = buf_adel ? EXC_ADEL_IF : 32'h0;
                    stallreq_if       = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state       <= IF_REQ;
            pc          <= RESET_PC;
            pend_br     <= 1'b0;
            pend_target <= '0;
            buf_inst    <= '0;
            buf_adel    <= 1'b0;
        end else if (flush) begin
            pc      <= new_pc;
            pend_br <= 1'b0;
            // A response still owed by memory must be swallowed before refetching.
            if ((state == IF_WAIT   && !inst_data_ok) ||
                (state == IF_REQ    && inst_req && inst_addr_ok) ||
                (state == IF_CANCEL && !inst_data_ok))
                state <= IF_CANCEL;
            else
                state <= IF_REQ;
        end else begin
            if (advance) begin
                pc      <= next_pc;
                pend_br <= 1'b0;
            end else if (branch_flag) begin
                pend_br     <= 1'b1;
                pend_target <= branch_target_address;
            end

            case (state)
                IF_REQ: begin
                    if (misaligned) begin
                        state    <= IF_VALID;
                        buf_inst <= '0;
                        buf_adel <= 1'b1;
                    end else if (inst_addr_ok) begin
                        state <= IF_WAIT;
                    end
                end
                IF_WAIT: begin
                    if (inst_data_ok) begin
                        if (hold) begin
                            state    <= IF_VALID;
                            buf_inst <= inst_rdata;
                            buf_adel <= 1'b0;
                        end else begin
                            state <= IF_REQ;
                        end
                    end
                end
                IF_VALID: begin
                    if (!hold) state <= IF_REQ;
                end
                IF_CANCEL: begin
                    if (inst_data_ok) state <= IF_REQ;
                end
                default: state <= IF_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed test-plan steps, then random traffic checked against
// a program-order PC-stream model and a random-latency memory with one outstanding slot.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] ADEL     = 32'h0000_0004;
`ifdef IF_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic        branch_flag = 1'b0;
    logic [31:0] bta = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        addr_ok = 1'b0;
    logic        data_ok = 1'b0;
    logic [31:0] rdata = '0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] exc;
    logic        stallreq_if;

    int checks = 0;
    int errors = 0;

    // memory model
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_resp = '0;
    int          aok_pct = 100;
    int          dlat_min = 0;
    int          dlat_max = 0;
    bit          ovr_v = 1'b0;
    logic [31:0] ovr_d = '0;

    // reference model: PC of the next instruction in program order
    logic [31:0] exp_pc = RESET_PC;
    bit          pend_v = 1'b0;
    logic [31:0] pend_t = '0;
    int          consumed = 0;
    bit          s_present;
    logic [31:0] s_addr;

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .stall                 (stall),
        .flush                 (flush),
        .new_pc                (new_pc),
        .branch_flag           (branch_flag),
        .branch_target_address (bta),
        .inst_req              (inst_req),
        .inst_addr             (inst_addr),
        .inst_addr_ok          (addr_ok),
        .inst_data_ok          (data_ok),
        .inst_rdata            (rdata),
        .if_pc                 (if_pc),
        .if_inst               (if_inst),
        .icache_excepttype     (exc),
        .stallreq_if           (stallreq_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit adel(input logic [31:0] a);
        return CHECK_EN && (a[1:0] != 2'b00);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        if (inst_req === 1'b1) begin
            check("req_addr", inst_addr, exp_pc);
            check("one_outstanding", {31'b0, mem_busy}, 32'd0);
        end
        if (adel(exp_pc)) check("no_req_misaligned", {31'b0, inst_req}, 32'd0);
        if (stallreq_if === 1'b0) begin
            check("if_pc", if_pc, exp_pc);
            check("if_inst", if_inst, adel(exp_pc) ? 32'h0 : mem_word(exp_pc));
            check("excepttype", exc, adel(exp_pc) ? ADEL : 32'h0);
        end else begin
            check("bubble_pc", if_pc, 32'h0);
            check("bubble_inst", if_inst, 32'h0);
            check("bubble_exc", exc, 32'h0);
            check("bubble_stallreq", {31'b0, stallreq_if}, 32'd1);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then compare outputs.
    task automatic drive(input bit st2, input bit bf, input logic [31:0] bt,
                         input bit fl, input logic [31:0] np);
        @(negedge clk);
        stall       = 6'($urandom);
        stall[2]    = st2;
        branch_flag = bf;
        bta         = bt;
        flush       = fl;
        new_pc      = np;
        addr_ok     = (inst_req === 1'b1) && !mem_busy && ($urandom_range(99) < aok_pct);
        data_ok     = mem_busy && (mem_cnt == 0);
        rdata       = data_ok ? mem_resp : $urandom;
        #1;
        s_present = (stallreq_if === 1'b0);
        s_addr    = inst_addr;
        model_check();
    endtask

    // Advance memory and model across the rising edge.
    task automatic tick();
        @(posedge clk);
        if (data_ok) mem_busy = 1'b0;
        else if (mem_busy && mem_cnt > 0) mem_cnt--;
        if (addr_ok) begin
            mem_busy = 1'b1;
            mem_cnt  = $urandom_range(dlat_max, dlat_min);
            mem_resp = ovr_v ? ovr_d : mem_word(s_addr);
            ovr_v    = 1'b0;
        end
        if (flush) begin
            exp_pc = new_pc;
            pend_v = 1'b0;
        end else if (s_present && !stall[2]) begin
            consumed++;
            exp_pc = branch_flag ? bta : (pend_v ? pend_t : exp_pc + 32'd4);
            pend_v = 1'b0;
        end else if (branch_flag) begin
            pend_v = 1'b1;
            pend_t = bta;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        flush = 1'b0; branch_flag = 1'b0; stall = '0;
        addr_ok = 1'b0; data_ok = 1'b0;
        mem_busy = 1'b0; mem_cnt = 0;
        exp_pc = RESET_PC; pend_v = 1'b0;
        #1;
        check("rst_inst_req", {31'b0, inst_req}, 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_exc", exc, 32'h0);
        check("rst_stallreq", {31'b0, stallreq_if}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic idle(input bit st2);
        drive(st2, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        int base;
        do_reset();

        // zero-wait memory, no stall
        idle(0); check("t1_req0", {31'b0, inst_req}, 32'd1);
        check("t1_addr0", inst_addr, 32'hBFC0_0000); check("t1_bub0", if_pc, 32'h0); tick();
        idle(0); check("t1_pc0", if_pc, 32'hBFC0_0000); check("t1_noreq", {31'b0, inst_req}, 32'd0); tick();
        idle(0); check("t1_addr1", inst_addr, 32'hBFC0_0004); check("t1_bub1", if_pc, 32'h0); tick();

        // stall while BFC00004 is presented
        idle(1); check("t2_pc", if_pc, 32'hBFC0_0004);
        check("t2_inst", if_inst, mem_word(32'hBFC0_0004)); tick();
        for (int k = 0; k < 2; k++) begin
            idle(1);
            check("t2_hold_pc", if_pc, 32'hBFC0_0004);
            check("t2_hold_inst", if_inst, mem_word(32'hBFC0_0004));
            check("t2_hold_noreq", {31'b0, inst_req}, 32'd0);
            tick();
        end
        idle(0); check("t2_rel_pc", if_pc, 32'hBFC0_0004); tick();
        idle(0); check("t2_next_addr", inst_addr, 32'hBFC0_0008); tick();
        idle(0); check("t2_next_pc", if_pc, 32'hBFC0_0008); tick();
        idle(0); check("t3_ds_addr", inst_addr, 32'hBFC0_000C); tick();

        // branch while delay slot is presented, then a branch during a stall
        drive(0, 1, 32'h8000_1000, 0, 0); check("t3_ds_pc", if_pc, 32'hBFC0_000C); tick();
        idle(0); check("t3_tgt_addr", inst_addr, 32'h8000_1000); tick();
        idle(1); check("t3_tgt_pc", if_pc, 32'h8000_1000); tick();
        drive(1, 1, 32'h8000_2000, 0, 0); tick();
        idle(1); tick();
        idle(0); tick();
        idle(0); check("t3_stall_br_addr", inst_addr, 32'h8000_2000); tick();
        idle(0); tick();

        // flush while waiting; stale response is DEADBEEF two cycles later
        dlat_min = 2; dlat_max = 2; ovr_v = 1'b1; ovr_d = 32'hDEAD_BEEF;
        idle(0); check("t4_req_addr", inst_addr, 32'h8000_2004); tick();
        dlat_min = 0; dlat_max = 0;
        drive(0, 0, 0, 1, 32'hBFC0_0380); check("t4_wait_bub", {31'b0, stallreq_if}, 32'd1); tick();
        for (int k = 0; k < 2; k++) begin
            idle(0);
            check("t4_cancel_noreq", {31'b0, inst_req}, 32'd0);
            check("t4_no_deadbeef", if_inst, 32'h0);
            tick();
        end
        idle(0); check("t4_new_addr", inst_addr, 32'hBFC0_0380); tick();

        // flush and branch in the same cycle
        drive(0, 1, 32'h8000_3000, 1, 32'h9FC0_1000); check("t5_pc", if_pc, 32'hBFC0_0380); tick();
        idle(0); check("t5_addr", inst_addr, 32'h9FC0_1000); tick();
        idle(0); tick();
        idle(0); check("t5_seq_addr", inst_addr, 32'h9FC0_1004); tick();

        // branch to a misaligned target
        drive(0, 1, 32'h8000_1002, 0, 0); tick();
        idle(0);
        if (CHECK_EN) begin
            check("t6_noreq", {31'b0, inst_req}, 32'd0);
            check("t6_pc", if_pc, 32'h8000_1002);
            check("t6_inst", if_inst, 32'h0);
            check("t6_exc", exc, ADEL);
        end else begin
            check("t6_req", {31'b0, inst_req}, 32'd1);
            check("t6_addr", inst_addr, 32'h8000_1002);
        end
        tick();
        drive(0, 0, 0, 1, 32'h8000_4000); tick();

        // random traffic
        aok_pct = 70; dlat_min = 0; dlat_max = 3;
        base = consumed;
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(99) < 30, $urandom_range(99) < 10,
                  $urandom & 32'hFFFF_FFFC, $urandom_range(99) < 3,
                  $urandom & 32'hFFFF_FFFC);
            tick();
        end
        check("progress", {31'b0, (consumed - base) > 200}, 32'd1);

        // reset while a response is outstanding
        aok_pct = 100; dlat_min = 3; dlat_max = 3;
        idle(0); tick();
        idle(0); tick();
        do_reset();
        dlat_min = 0; dlat_max = 0;
        idle(0); check("t7_addr", inst_addr, RESET_PC);
        check("t7_req", {31'b0, inst_req}, 32'd1); tick();
        idle(0); check("t7_pc", if_pc, RESET_PC); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
